// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment frame decoder: glyph patterns
// (segments as gfedcba, active-high), symbol codes and the capture FSM states.
package seven_segment_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int CODE_W    = 5;
    localparam int FRAME_W   = NUM_SLOTS * CODE_W;

    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_A     = 7'h77;
    localparam logic [6:0] GLYPH_B     = 7'h7C;
    localparam logic [6:0] GLYPH_C     = 7'h39;
    localparam logic [6:0] GLYPH_D     = 7'h5E;
    localparam logic [6:0] GLYPH_E     = 7'h79;
    localparam logic [6:0] GLYPH_F     = 7'h71;
    localparam logic [6:0] GLYPH_DASH  = 7'h40;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    localparam logic [4:0] CODE_DASH  = 5'd16;
    localparam logic [4:0] CODE_BLANK = 5'd17;
    localparam logic [4:0] CODE_BAD   = 5'd18;

    typedef enum logic {
        IDLE,
        CAPTURE
    } cap_state_t;

    // Position of the (single) low bit of an active-low anode vector.
    function automatic logic [2:0] slot_index(input logic [7:0] an);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!an[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph decoder: 7 active-high segments (gfedcba) to a 5-bit
// symbol code. Unknown patterns map to CODE_BAD and raise bad.
module seg_glyph_decode
    import seven_segment_pkg::*;
(
    input  logic [6:0] seg,
    output logic [4:0] code,
    output logic       bad
);

    // Table lookup; anything outside the table is flagged.
    always_comb begin
        code = CODE_BAD;
        bad  = 1'b0;
        case (seg)
            GLYPH_0:     code = 5'd0;
            GLYPH_1:     code = 5'd1;
            GLYPH_2:     code = 5'd2;
            GLYPH_3:     code = 5'd3;
            GLYPH_4:     code = 5'd4;
            GLYPH_5:     code = 5'd5;
            GLYPH_6:     code = 5'd6;
            GLYPH_7:     code = 5'd7;
            GLYPH_8:     code = 5'd8;
            GLYPH_9:     code = 5'd9;
            GLYPH_A:     code = 5'd10;
            GLYPH_B:     code = 5'd11;
            GLYPH_C:     code = 5'd12;
            GLYPH_D:     code = 5'd13;
            GLYPH_E:     code = 5'd14;
            GLYPH_F:     code = 5'd15;
            GLYPH_DASH:  code = CODE_DASH;
            GLYPH_BLANK: code = CODE_BLANK;
            default: begin
                code = CODE_BAD;
                bad  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seven_segment_frame_decoder.sv
// Snoops a scanned 8-digit seven-segment display (active-low anodes and
// cathodes), decodes each settled digit and assembles full frames that are
// handed out over a valid/ready interface.
// Optional: define SEVSEG_REPEAT_FILTER_EN to drop frames identical to the
// last frame loaded into the output register.
module seven_segment_frame_decoder
    import seven_segment_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int FRAME_TIMEOUT = 1000000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [6:0]  cat_in,
    input  logic [7:0]  an_in,
    input  logic        frame_ready_in,
    output logic        frame_valid_out,
    output logic [39:0] frame_out,
    output logic        glyph_err_out,
    output logic        seq_err_out,
    output logic        overflow_out
);

    localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = (FRAME_TIMEOUT > 2) ? $clog2(FRAME_TIMEOUT) : 1;
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX    = TW'(FRAME_TIMEOUT - 1);

    logic [7:0]         an_q, an_p;
    logic [6:0]         cat_q, cat_p;
    logic [SW-1:0]      settle_cnt;
    logic               committed;
    logic               changed, commit, one_hot, slot_commit;
    logic [7:0]         an_hot;
    logic [2:0]         slot;
    logic [4:0]         code;
    logic               bad;

    cap_state_t         state, state_n;
    logic [2:0]         expected, expected_n;
    logic [TW-1:0]      tmo_cnt, tmo_n;
    logic               buf_wr, frame_done, seq_pulse;
    logic [FRAME_W-1:0] cap_buf, frame_next;

    logic               xfer, can_load, is_repeat;

    // Register the scan lines once, and keep the previous registered copy
    // so stability is judged entirely on registered values.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            an_q  <= 8'hFF;
            cat_q <= 7'h7F;
            an_p  <= 8'hFF;
            cat_p <= 7'h7F;
        end else begin
            an_q  <= an_in;
            cat_q <= cat_in;
            an_p  <= an_q;
            cat_p <= cat_q;
        end
    end

    assign changed     = {an_q, cat_q} != {an_p, cat_p};
    assign commit      = !changed && (settle_cnt == SETTLE_MAX) && !committed;
    assign an_hot      = ~an_q;
    assign one_hot     = (an_hot != 8'h00) && ((an_hot & (an_hot - 8'd1)) == 8'h00);
    assign slot_commit = commit && one_hot;
    assign slot        = slot_index(an_q);

    seg_glyph_decode u_decode (
        .seg  (~cat_q),
        .code (code),
        .bad  (bad)
    );

    // Stability counter saturates; committed guarantees one commit per period.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            settle_cnt <= '0;
            committed  <= 1'b0;
        end else if (changed) begin
            settle_cnt <= '0;
            committed  <= 1'b0;
        end else begin
            if (settle_cnt != SETTLE_MAX) settle_cnt <= settle_cnt + 1'b1;
            if (commit) committed <= 1'b1;
        end
    end

    // Capture FSM next-state: in-order slot tracking, sequence errors, timeout.
    always_comb begin
        state_n    = state;
        expected_n = expected;
        tmo_n      = tmo_cnt;
        buf_wr     = 1'b0;
        frame_done = 1'b0;
        seq_pulse  = 1'b0;
        case (state)
            IDLE: begin
                tmo_n = '0;
                if (slot_commit && slot == 3'd0) begin
                    buf_wr     = 1'b1;
                    expected_n = 3'd1;
                    state_n    = CAPTURE;
                end
            end
            CAPTURE: begin
                tmo_n = tmo_cnt + 1'b1;
                if (slot_commit) begin
                    if (slot == expected) begin
                        buf_wr     = 1'b1;
                        tmo_n      = '0;
                        expected_n = expected + 3'd1;
                        if (slot == 3'd7) begin
                            frame_done = 1'b1;
                            state_n    = IDLE;
                        end
                    end else begin
                        seq_pulse = 1'b1;
                        state_n   = IDLE;
                    end
                end else if (tmo_cnt == TMO_MAX) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Capture buffer contents including the slot being written this cycle,
    // so a completing frame can be loaded straight into the output register.
    always_comb begin
        frame_next = cap_buf;
        if (buf_wr) frame_next[int'(slot)*CODE_W +: CODE_W] = code;
    end

    // Capture FSM state, slot tracking and capture buffer.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state    <= IDLE;
            expected <= 3'd0;
            tmo_cnt  <= '0;
            cap_buf  <= '0;
        end else begin
            state    <= state_n;
            expected <= expected_n;
            tmo_cnt  <= tmo_n;
            cap_buf  <= frame_next;
        end
    end

    assign xfer     = frame_valid_out && frame_ready_in;
    assign can_load = !frame_valid_out || xfer;

`ifdef SEVSEG_REPEAT_FILTER_EN
    logic [FRAME_W-1:0] last_frame;
    logic               last_loaded;

    assign is_repeat = last_loaded && (frame_next == last_frame);

    // Remember the most recently loaded frame for repeat suppression.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            last_frame  <= '0;
            last_loaded <= 1'b0;
        end else if (frame_done && !is_repeat && can_load) begin
            last_frame  <= frame_next;
            last_loaded <= 1'b1;
        end
    end
`else
    assign is_repeat = 1'b0;
`endif

    // Output register: load on completion when free, otherwise flag overflow.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            frame_valid_out <= 1'b0;
            frame_out       <= '0;
            overflow_out    <= 1'b0;
        end else begin
            overflow_out <= 1'b0;
            if (frame_done && !is_repeat) begin
                if (can_load) begin
                    frame_out       <= frame_next;
                    frame_valid_out <= 1'b1;
                end else begin
                    overflow_out <= 1'b1;
                end
            end else if (xfer) begin
                frame_valid_out <= 1'b0;
            end
        end
    end

    // Error pulses, one cycle after the event that raised them.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            glyph_err_out <= 1'b0;
            seq_err_out   <= 1'b0;
        end else begin
            glyph_err_out <= slot_commit && bad;
            seq_err_out   <= seq_pulse;
        end
    end

endmodule

// File: tb/tb_seven_segment_frame_decoder.sv
// Bench for seven_segment_frame_decoder: a scan driver paints glyphs onto the
// active-low lines, a monitor counts pulses and collects transferred frames,
// and expected frames come from a glyph-table lookup model.
module tb_seven_segment_frame_decoder;

    localparam int SETTLE = 16;
    localparam int TMO    = 500;

    typedef logic [7:0][6:0] pats_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  cat = 7'h7F;
    logic [7:0]  an = 8'hFF;
    logic        ready = 1'b0;
    logic        valid;
    logic [39:0] fout;
    logic        gerr, serr, ovf;

    int checks = 0;
    int errors = 0;
    int n_rise, n_gerr, n_serr, n_ovf;
    logic [39:0] xq[$];

    logic [6:0] gtab [18] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
                              7'h40, 7'h00};

    always #5 clk = ~clk;

    seven_segment_frame_decoder #(.SETTLE_CYCLES(SETTLE), .FRAME_TIMEOUT(TMO)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .cat_in          (cat),
        .an_in           (an),
        .frame_ready_in  (ready),
        .frame_valid_out (valid),
        .frame_out       (fout),
        .glyph_err_out   (gerr),
        .seq_err_out     (serr),
        .overflow_out    (ovf)
    );

    // Reference model: symbol code is the glyph's index in the table, else 18.
    function automatic logic [4:0] ref_code(input logic [6:0] seg);
        for (int i = 0; i < 18; i++) if (gtab[i] == seg) return 5'(i);
        return 5'd18;
    endfunction

    function automatic logic [39:0] ref_frame(input pats_t p);
        logic [39:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) f[5*i +: 5] = ref_code(p[i]);
        return f;
    endfunction

    function automatic pats_t rand_pats();
        pats_t p;
        for (int i = 0; i < 8; i++) p[i] = gtab[$urandom_range(0, 17)];
        return p;
    endfunction

    // Monitor, sampled just after the falling edge: pulses, valid rises,
    // transfers, and frame_out/valid hold while stalled.
    logic        hold = 1'b0;
    logic        pvld = 1'b0;
    logic [39:0] pfr;
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            hold = 1'b0;
            pvld = 1'b0;
        end else begin
            if (gerr) n_gerr++;
            if (serr) n_serr++;
            if (ovf) n_ovf++;
            if (valid && !pvld) n_rise++;
            if (hold) begin
                checks++;
                if (valid !== 1'b1 || fout !== pfr) begin
                    errors++;
                    $display("FAIL hold valid=%b frame=%h want valid=1 frame=%h", valid, fout, pfr);
                end
            end
            if (valid && ready) xq.push_back(fout);
            hold = valid && !ready;
            pfr  = fout;
            pvld = valid;
        end
    end

    task automatic clear_counts();
        n_rise = 0; n_gerr = 0; n_serr = 0; n_ovf = 0;
        xq.delete();
    endtask

    // Lines change at a falling edge and are held for dwell cycles.
    task automatic scan_slot(input int slot, input logic [6:0] seg, input int dwell);
        an  = ~(8'd1 << slot);
        cat = ~seg;
        repeat (dwell) @(negedge clk);
    endtask

    task automatic scan_frame(input pats_t p, input int dwell);
        for (int s = 0; s < 8; s++) scan_slot(s, p[s], dwell);
    endtask

    task automatic dark(input int n);
        an  = 8'hFF;
        cat = 7'h7F;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({valid, gerr, serr, ovf} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {valid, gerr, serr, ovf});
        end
        checks++;
        if (fout !== 40'h0) begin
            errors++;
            $display("FAIL reset_frame got %h want 0", fout);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_frame();
        pats_t p;
        logic [39:0] exp;
        int lat;
        clear_counts();
        ready = 1'b1;
        p = {gtab[16], gtab[7], gtab[17], gtab[2], gtab[10], gtab[17], gtab[5], gtab[3]};
        exp = ref_frame(p);
        for (int s = 0; s < 7; s++) scan_slot(s, p[s], 100);
        an = 8'h7F;
        cat = ~p[7];
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (valid && lat == 0) lat = i;
        end
        dark(40);
        checks++;
        if (lat < SETTLE || lat > SETTLE + 3) begin
            errors++;
            $display("FAIL basic_latency got %0d want %0d..%0d", lat, SETTLE, SETTLE + 3);
        end
        checks++;
        if (n_rise != 1) begin
            errors++;
            $display("FAIL basic_rise got %0d want 1", n_rise);
        end
        checks++;
        if (xq.size() != 1 || xq[0] !== exp) begin
            errors++;
            $display("FAIL basic_frame got n=%0d %h want %h", xq.size(), (xq.size() > 0) ? xq[0] : 40'h0, exp);
        end
        checks++;
        if (n_gerr + n_serr + n_ovf != 0) begin
            errors++;
            $display("FAIL basic_pulses got g=%0d s=%0d o=%0d want 0", n_gerr, n_serr, n_ovf);
        end
    endtask

    task automatic test_backpressure();
        pats_t pa, pb;
        logic [39:0] ea;
        clear_counts();
        ready = 1'b0;
        pa = rand_pats();
        pb = rand_pats();
        ea = ref_frame(pa);
        scan_frame(pa, 100);
        scan_frame(pb, 100);
        dark(40);
        checks++;
        if (n_ovf != 1) begin
            errors++;
            $display("FAIL bp_overflow got %0d want 1", n_ovf);
        end
        checks++;
        if (valid !== 1'b1 || fout !== ea) begin
            errors++;
            $display("FAIL bp_held got valid=%b %h want valid=1 %h", valid, fout, ea);
        end
        ready = 1'b1;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_clear got valid=%b want 0", valid);
        end
        checks++;
        if (xq.size() != 1 || xq[0] !== ea) begin
            errors++;
            $display("FAIL bp_xfer got n=%0d %h want %h", xq.size(), (xq.size() > 0) ? xq[0] : 40'h0, ea);
        end
        dark(20);
    endtask

    task automatic test_seq_err();
        pats_t p;
        logic [39:0] exp;
        clear_counts();
        ready = 1'b1;
        scan_slot(0, gtab[$urandom_range(0, 17)], 100);
        scan_slot(2, gtab[$urandom_range(0, 17)], 100);
        dark(40);
        checks++;
        if (n_serr != 1 || n_rise != 0) begin
            errors++;
            $display("FAIL seq_err got serr=%0d rise=%0d want 1 0", n_serr, n_rise);
        end
        p = rand_pats();
        exp = ref_frame(p);
        scan_frame(p, 60);
        dark(40);
        checks++;
        if (n_rise != 1 || xq.size() != 1 || xq[0] !== exp) begin
            errors++;
            $display("FAIL seq_recover got n=%0d %h want 1 %h", xq.size(), (xq.size() > 0) ? xq[0] : 40'h0, exp);
        end
    endtask

    task automatic test_short_dwell();
        clear_counts();
        ready = 1'b1;
        scan_frame(rand_pats(), 10);
        dark(40);
        an  = 8'h00;
        cat = ~7'h49;
        repeat (1000) @(negedge clk);
        dark(40);
        checks++;
        if (n_rise != 0 || n_gerr != 0 || n_serr != 0) begin
            errors++;
            $display("FAIL short_dwell got rise=%0d gerr=%0d serr=%0d want 0", n_rise, n_gerr, n_serr);
        end
    endtask

    task automatic test_bad_glyph();
        pats_t p;
        logic [39:0] exp;
        clear_counts();
        ready = 1'b1;
        p = rand_pats();
        p[4] = 7'h49;
        exp = ref_frame(p);
        scan_frame(p, 100);
        dark(40);
        checks++;
        if (n_gerr != 1) begin
            errors++;
            $display("FAIL bad_glyph_pulse got %0d want 1", n_gerr);
        end
        checks++;
        if (n_rise != 1 || xq.size() != 1 || xq[0] !== exp) begin
            errors++;
            $display("FAIL bad_glyph_frame got n=%0d %h want %h", xq.size(), (xq.size() > 0) ? xq[0] : 40'h0, exp);
        end
    endtask

    task automatic test_reset_mid();
        pats_t p;
        logic [39:0] exp;
        clear_counts();
        ready = 1'b0;
        scan_frame(rand_pats(), 60);
        dark(20);
        p = rand_pats();
        for (int s = 0; s < 5; s++) scan_slot(s, p[s], 60);
        scan_slot(5, p[5], 30);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (valid !== 1'b0 || fout !== 40'h0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL midreset got valid=%b %h ovf=%b want 0", valid, fout, ovf);
        end
        rst = 1'b1;
        clear_counts();
        repeat (60) @(negedge clk);
        scan_slot(6, p[6], 60);
        scan_slot(7, p[7], 60);
        dark(40);
        checks++;
        if (n_rise != 0 || valid !== 1'b0 || n_serr != 0) begin
            errors++;
            $display("FAIL midreset_partial got rise=%0d valid=%b serr=%0d want 0", n_rise, valid, n_serr);
        end
        ready = 1'b1;
        p = rand_pats();
        exp = ref_frame(p);
        scan_frame(p, 60);
        dark(40);
        checks++;
        if (n_rise != 1 || xq.size() != 1 || xq[0] !== exp) begin
            errors++;
            $display("FAIL midreset_next got n=%0d %h want %h", xq.size(), (xq.size() > 0) ? xq[0] : 40'h0, exp);
        end
    endtask

    task automatic test_timeout();
        pats_t p;
        logic [39:0] exp;
        clear_counts();
        ready = 1'b1;
        p = rand_pats();
        for (int s = 0; s < 4; s++) scan_slot(s, p[s], 60);
        dark(TMO + 100);
        for (int s = 4; s < 8; s++) scan_slot(s, p[s], 60);
        dark(40);
        checks++;
        if (n_rise != 0 || n_serr != 0) begin
            errors++;
            $display("FAIL timeout got rise=%0d serr=%0d want 0 0", n_rise, n_serr);
        end
        p = rand_pats();
        exp = ref_frame(p);
        scan_frame(p, 60);
        dark(40);
        checks++;
        if (n_rise != 1 || xq.size() != 1 || xq[0] !== exp) begin
            errors++;
            $display("FAIL timeout_next got n=%0d %h want %h", xq.size(), (xq.size() > 0) ? xq[0] : 40'h0, exp);
        end
    endtask

    task automatic test_back_to_back();
        pats_t p;
        logic [39:0] expq[$];
        clear_counts();
        ready = 1'b1;
        for (int f = 0; f < 8; f++) begin
            p = rand_pats();
            expq.push_back(ref_frame(p));
            for (int s = 0; s < 8; s++) scan_slot(s, p[s], $urandom_range(20, 60));
        end
        dark(40);
        checks++;
        if (n_rise != 8 || xq.size() != 8) begin
            errors++;
            $display("FAIL b2b_count got rise=%0d xfer=%0d want 8 8", n_rise, xq.size());
        end
        for (int f = 0; f < 8; f++) begin
            if (f < xq.size()) begin
                checks++;
                if (xq[f] !== expq[f]) begin
                    errors++;
                    $display("FAIL b2b_frame%0d got %h want %h", f, xq[f], expq[f]);
                end
            end
        end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_seq_err();
        test_short_dwell();
        test_bad_glyph();
        test_reset_mid();
        test_timeout();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
